// File: rtl/reflet_float_au_arbiter_pkg.sv
// Shared encodings for the float AU arbiter.
// FSM states and opcode width reused by AU and decoder.
package reflet_float_au_arbiter_pkg;

  localparam int opcode_w = 6;

  localparam logic [1:0] st_idle   = 2'd0;
  localparam logic [1:0] st_launch = 2'd1;
  localparam logic [1:0] st_wait   = 2'd2;
  localparam logic [1:0] st_done   = 2'd3;

  function automatic logic rr_pick(
    input logic       last,
    input logic [1:0] req
  );
    rr_pick = req[~last] ? ~last : last;
  endfunction

endpackage

// File: rtl/reflet_float_au_arbiter_rr.sv
// Two-way round-robin grant.
// Prefers the side that did not win last time.
module reflet_rr_arbiter2
  import reflet_float_au_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       any
);

  logic last_grant;

  assign any   = |req;
  assign grant = rr_pick(last_grant, req);

  // Remember the winner so the other side gets priority next
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (take && any) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/reflet_float_au_arbiter.sv
// Shares one float AU between two requesters.
// Round-robin grant, operand latch, enable/ready sequencing.
module reflet_float_au_arbiter
  import reflet_float_au_arbiter_pkg::*;
#(
  parameter int float_size = 32,
  parameter int timeout    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [opcode_w-1:0]   req0_opcode,
  input  logic [float_size-1:0] req0_in1,
  input  logic [float_size-1:0] req0_in2,
  input  logic [float_size-1:0] req0_in3,
  input  logic                  req1_valid,
  input  logic [opcode_w-1:0]   req1_opcode,
  input  logic [float_size-1:0] req1_in1,
  input  logic [float_size-1:0] req1_in2,
  input  logic [float_size-1:0] req1_in3,
  output logic                  req0_done,
  output logic                  req1_done,
  output logic [float_size-1:0] res_out,
  output logic                  flag_res_out,
  output logic                  error,
  output logic                  busy,
  output logic                  au_enable,
  output logic [opcode_w-1:0]   au_opcode,
  output logic [float_size-1:0] au_in1,
  output logic [float_size-1:0] au_in2,
  output logic [float_size-1:0] au_in3,
  input  logic                  au_ready,
  input  logic [float_size-1:0] au_out,
  input  logic                  au_flag
);

  localparam logic [7:0] to_lim = 8'(timeout);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       gnt_r;
  logic       gnt;
  logic       any;

  reflet_rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({req1_valid, req0_valid}),
    .take  (state == st_idle),
    .grant (gnt),
    .any   (any)
  );

  assign busy      = (state != st_idle);
  assign au_enable = (state == st_launch) ||
                     (state == st_wait);
  assign req0_done = (state == st_done) && !gnt_r;
  assign req1_done = (state == st_done) && gnt_r;

  // Grant, launch, wait for ready or timeout, then report
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= st_idle;
      cnt          <= 8'd0;
      gnt_r        <= 1'b0;
      au_opcode    <= '0;
      au_in1       <= '0;
      au_in2       <= '0;
      au_in3       <= '0;
      res_out      <= '0;
      flag_res_out <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (any) begin
            gnt_r     <= gnt;
            au_opcode <= gnt ? req1_opcode : req0_opcode;
            au_in1    <= gnt ? req1_in1 : req0_in1;
            au_in2    <= gnt ? req1_in2 : req0_in2;
            au_in3    <= gnt ? req1_in3 : req0_in3;
            state     <= st_launch;
          end
        end
        st_launch: begin
          cnt   <= 8'd0;
          state <= st_wait;
        end
        st_wait: begin
          if (au_ready) begin
            res_out      <= au_out;
            flag_res_out <= au_flag;
            error        <= 1'b0;
            state        <= st_done;
          end else if (cnt == to_lim) begin
            error <= 1'b1;
            state <= st_done;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        st_done: begin
          state <= st_idle;
        end
        default: begin
          state <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_float_au_arbiter.sv
// Bench for the float AU arbiter with a fixed-latency AU stub.
// Random and directed operations checked against a request-level model.
module tb_reflet_float_au_arbiter;

  localparam int fs = 32;
  localparam int to = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [5:0]    req0_opcode, req1_opcode;
  logic [fs-1:0] req0_in1, req0_in2, req0_in3;
  logic [fs-1:0] req1_in1, req1_in2, req1_in3;
  logic          req0_done, req1_done;
  logic [fs-1:0] res_out;
  logic          flag_res_out, error, busy, au_enable;
  logic [5:0]    au_opcode;
  logic [fs-1:0] au_in1, au_in2, au_in3;
  logic          au_ready;
  logic [fs-1:0] au_out;
  logic          au_flag;

  int vectors = 0;
  int miscompares = 0;

  // AU stub: ready in the lat-th enabled cycle after launch
  int   lat = 1;
  logic stale = 1'b0;
  logic stuck = 1'b0;
  int   scnt = 0;

  // Model state
  int            mdl_last;
  logic [fs-1:0] mdl_res;
  logic          mdl_flag;

  always #5 clk = ~clk;

  reflet_float_au_arbiter #(.float_size(fs), .timeout(to)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_in3(req0_in3),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_in3(req1_in3),
    .req0_done(req0_done), .req1_done(req1_done),
    .res_out(res_out), .flag_res_out(flag_res_out),
    .error(error), .busy(busy), .au_enable(au_enable),
    .au_opcode(au_opcode), .au_in1(au_in1),
    .au_in2(au_in2), .au_in3(au_in3),
    .au_ready(au_ready), .au_out(au_out), .au_flag(au_flag)
  );

  // Count enabled cycles for the latency stub
  always @(posedge clk) begin
    if (!au_enable) scnt <= 0;
    else scnt <= scnt + 1;
  end

  assign au_ready = stale ? 1'b1 :
                    (!stuck && au_enable && scnt >= lat);
  assign au_out  = au_in1;
  assign au_flag = au_opcode[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int mdl_pick(input bit v0, input bit v1);
    int pref;
    pref = 1 - mdl_last;
    if ((pref == 0) ? v0 : v1) return pref;
    return 1 - pref;
  endfunction

  task automatic scramble();
    req0_in1 = $urandom; req0_in2 = $urandom; req0_in3 = $urandom;
    req1_in1 = $urandom; req1_in2 = $urandom; req1_in3 = $urandom;
    req0_opcode = 6'($urandom); req1_opcode = 6'($urandom);
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
  endtask

  task automatic wait_done(input logic scr,
                           input logic [31:0] exp_in1,
                           output int who, output int tk);
    who = -1;
    tk = 0;
    while (tk < 300) begin
      tick();
      tk++;
      if (scr && tk == 2) begin
        scramble();
        #1;
        check("isolate_au_in1", au_in1, exp_in1);
      end
      if (req0_done || req1_done) begin
        check("one_done", 32'(req0_done & req1_done), 32'd0);
        who = req1_done ? 1 : 0;
        break;
      end
    end
    if (who < 0) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic expect_op(input int exp_who, input int exp_cyc,
                           input logic [31:0] exp_res,
                           input logic exp_flag, input logic exp_err,
                           input int who, input int tk);
    check("winner", 32'(who), 32'(exp_who));
    check("latency", 32'(tk + 1), 32'(exp_cyc));
    check("res_out", res_out, exp_res);
    check("flag_res_out", 32'(flag_res_out), 32'(exp_flag));
    check("error", 32'(error), 32'(exp_err));
    if (!exp_err) begin
      mdl_res = exp_res;
      mdl_flag = exp_flag;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    mdl_last = 1;
    mdl_res = '0;
    mdl_flag = 1'b0;
  endtask

  initial begin
    int who, tk, ew, v;
    logic [31:0] er;
    logic ef;

    req0_valid = 0; req1_valid = 0;
    req0_opcode = 0; req1_opcode = 0;
    req0_in1 = 0; req0_in2 = 0; req0_in3 = 0;
    req1_in1 = 0; req1_in2 = 0; req1_in3 = 0;
    mdl_last = 1; mdl_res = 0; mdl_flag = 0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(au_enable), 32'd0);
    check("rst_done", 32'({req1_done, req0_done}), 32'd0);
    check("rst_res", res_out, 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_flag", 32'(flag_res_out), 32'd0);
    check("rst_au_in1", au_in1, 32'd0);
    reset = 1'b1;
    tick();

    // Single request, L=3
    lat = 3;
    req0_valid = 1;
    req0_opcode = 6'd1;
    req0_in1 = 32'h42600000;
    req0_in2 = $urandom;
    req0_in3 = $urandom;
    ew = mdl_pick(1, 0);
    mdl_last = ew;
    tick();
    check("launch_en", 32'(au_enable), 32'd1);
    check("launch_busy", 32'(busy), 32'd1);
    check("launch_in1", au_in1, 32'h42600000);
    check("launch_in2", au_in2, req0_in2);
    check("launch_opc", 32'(au_opcode), 32'd1);
    tick();
    req0_in1 = 32'h11111111;
    wait_done(1'b0, 32'h0, who, tk);
    tk = tk + 2;
    check("hold_au_in1", au_in1, 32'h42600000);
    check("done_en_low", 32'(au_enable), 32'd0);
    expect_op(ew, 6, 32'h42600000, 1'b1, 1'b0, who, tk);
    req0_valid = 0;
    tick();
    check("pulse_width", 32'(req0_done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Contention after reset: 0,1,0,1
    do_reset();
    lat = 2;
    req0_valid = 1; req0_opcode = 6'd1; req0_in1 = 32'h42600000;
    req1_valid = 1; req1_opcode = 6'd2; req1_in1 = 32'hC4094000;
    for (int i = 0; i < 4; i++) begin
      ew = mdl_pick(1, 1);
      mdl_last = ew;
      check("rr_order", 32'(ew), 32'(i % 2));
      er = ew ? 32'hC4094000 : 32'h42600000;
      ef = ew ? 1'b0 : 1'b1;
      wait_done(1'b0, 32'h0, who, tk);
      expect_op(ew, 5, er, ef, 1'b0, who, tk);
      tick();
      check("cont_pulse", 32'({req1_done, req0_done}), 32'd0);
    end
    req0_valid = 0; req1_valid = 0;
    tick();
    check("cont_idle", 32'(busy), 32'd0);

    // Timeout: ready never rises
    stuck = 1;
    req1_valid = 1; req1_opcode = 6'd3; req1_in1 = $urandom;
    ew = mdl_pick(0, 1);
    mdl_last = ew;
    wait_done(1'b0, 32'h0, who, tk);
    expect_op(ew, 3 + to + 1, mdl_res, mdl_flag, 1'b1, who, tk);
    req1_valid = 0;
    stuck = 0;
    tick();
    check("to_busy_fall", 32'(busy), 32'd0);
    check("to_err_hold", 32'(error), 32'd1);

    // Random operations with isolation scramble
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(1, 3);
      req0_valid = v[0]; req1_valid = v[1];
      req0_opcode = 6'($urandom); req1_opcode = 6'($urandom);
      req0_in1 = $urandom; req0_in2 = $urandom; req0_in3 = $urandom;
      req1_in1 = $urandom; req1_in2 = $urandom; req1_in3 = $urandom;
      stale = ($urandom_range(0, 3) == 0);
      lat = stale ? 1 : $urandom_range(1, 6);
      ew = mdl_pick(v[0], v[1]);
      mdl_last = ew;
      er = ew ? req1_in1 : req0_in1;
      ef = ew ? req1_opcode[0] : req0_opcode[0];
      wait_done(1'b1, er, who, tk);
      expect_op(ew, 3 + lat, er, ef, 1'b0, who, tk);
      req0_valid = 0; req1_valid = 0;
      stale = 0;
      tick();
      check("rnd_pulse", 32'({req1_done, req0_done}), 32'd0);
      check("rnd_idle", 32'(busy), 32'd0);
    end

    // Reset in the middle of WAIT
    stuck = 1;
    req1_valid = 1; req1_in1 = $urandom;
    tick(); tick(); tick();
    check("mid_en", 32'(au_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_en", 32'(au_enable), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_done", 32'({req1_done, req0_done}), 32'd0);
    end
    reset = 1'b1;
    mdl_last = 1; mdl_res = 0; mdl_flag = 0;
    stuck = 0;
    lat = 2;
    req0_valid = 1; req0_opcode = 6'd4; req0_in1 = 32'h43A20000;
    req1_valid = 1;
    ew = mdl_pick(1, 1);
    mdl_last = ew;
    wait_done(1'b0, 32'h0, who, tk);
    expect_op(ew, 5, 32'h43A20000, 1'b0, 1'b0, who, tk);
    req0_valid = 0; req1_valid = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
